// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle for the Sobel neighbourhood generator.
// The master drives the camera pixel stream; the slave produces windows.
interface sobel_window_gen_if #(
  parameter int COORD_BITS = 11
);
  logic                  pix_valid;
  logic [7:0]            pix_in;
  logic                  sof;
  logic                  win_valid;
  logic [7:0]            ul, uc, ur;
  logic [7:0]            ml, mc, mr;
  logic [7:0]            dl, dc, dr;
  logic [COORD_BITS-1:0] coordinate_X;
  logic [COORD_BITS-1:0] coordinate_Y;
  logic                  frame_done;
  logic                  sync_err;

  modport master (
    output pix_valid, pix_in, sof,
    input  win_valid, ul, uc, ur, ml, mc, mr, dl, dc, dr,
    input  coordinate_X, coordinate_Y, frame_done, sync_err
  );

  modport slave (
    input  pix_valid, pix_in, sof,
    output win_valid, ul, uc, ur, ml, mc, mr, dl, dc, dr,
    output coordinate_X, coordinate_Y, frame_done, sync_err
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the Sobel edge-detect path.
// Two line memories hold the previous two rows; only interior windows
// (full neighbourhood) are emitted, one cycle after the pixel is accepted.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for pix_valid && sof; all other pixels are dropped
// STREAM | accepting pixels in raster order, row/col track the position
module sobel_window_gen #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int COORD_BITS = 11
) (
  input logic               CAMERA_CLK,
  input logic               rst,
  sobel_window_gen_if.slave bus
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COORD_BITS-1:0] LAST_ROW = COORD_BITS'(HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] LAST_COL = COORD_BITS'(WIDTH - 1);
  localparam logic [COORD_BITS-1:0] TWO      = COORD_BITS'(2);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state, stateNext;
  logic [COORD_BITS-1:0] row, col, rowNext, colNext;
  logic [COORD_BITS-1:0] pixRow, pixCol;
  logic                  accept, restart, midSof, lastPix, emit;
  logic [AW-1:0]         memAddr;
  logic [7:0]            lineA [WIDTH];
  logic [7:0]            lineB [WIDTH];
  logic [7:0]            a, b;
  // Two previous columns per window row; the third (right) column is the
  // live a/b/pix_in value, so it never needs its own register.
  logic [7:0]            top0, top1, mid0, mid1, bot0, bot1;

  // Position of the current pixel, acceptance, and next-state/counter logic.
  always_comb begin
    stateNext = state;
    rowNext   = row;
    colNext   = col;
    restart   = bus.pix_valid && bus.sof;
    midSof    = restart && (state == STREAM);
    accept    = bus.pix_valid && ((state == STREAM) || bus.sof);
    pixRow    = restart ? '0 : row;
    pixCol    = restart ? '0 : col;
    lastPix   = accept && !restart && (row == LAST_ROW) && (col == LAST_COL);
    emit      = accept && (pixRow >= TWO) && (pixCol >= TWO);
    if (accept) begin
      if (lastPix) begin
        stateNext = IDLE;
        rowNext   = '0;
        colNext   = '0;
      end else begin
        stateNext = STREAM;
        if (pixCol == LAST_COL) begin
          colNext = '0;
          rowNext = pixRow + 1'b1;
        end else begin
          colNext = pixCol + 1'b1;
          rowNext = pixRow;
        end
      end
    end
  end

  // FSM state and raster-position counters.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= stateNext;
      row   <= rowNext;
      col   <= colNext;
    end
  end

  assign memAddr = pixCol[AW-1:0];
  assign a       = lineA[memAddr];
  assign b       = lineB[memAddr];

  // Line memories: lineA ages into lineB as the new row overwrites lineA.
  // Contents are never reset; rows 0 and 1 refill them before any window.
  always_ff @(posedge CAMERA_CLK) begin
    if (accept) begin
      lineB[memAddr] <= a;
      lineA[memAddr] <= bus.pix_in;
    end
  end

  // Column shift registers; not cleared at row start because columns 0 and
  // 1 of each row refill them before the first window of that row.
  always_ff @(posedge CAMERA_CLK) begin
    if (accept) begin
      top0 <= top1;
      top1 <= b;
      mid0 <= mid1;
      mid1 <= a;
      bot0 <= bot1;
      bot1 <= bus.pix_in;
    end
  end

  // Registered window taps, coordinates and status flags.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      bus.win_valid    <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.sync_err     <= 1'b0;
      bus.ul           <= '0;
      bus.uc           <= '0;
      bus.ur           <= '0;
      bus.ml           <= '0;
      bus.mc           <= '0;
      bus.mr           <= '0;
      bus.dl           <= '0;
      bus.dc           <= '0;
      bus.dr           <= '0;
      bus.coordinate_X <= '0;
      bus.coordinate_Y <= '0;
    end else begin
      bus.win_valid  <= emit;
      bus.frame_done <= lastPix;
      if (midSof) begin
        bus.sync_err <= 1'b1;
      end
      if (emit) begin
        bus.ul           <= top0;
        bus.uc           <= top1;
        bus.ur           <= b;
        bus.ml           <= mid0;
        bus.mc           <= mid1;
        bus.mr           <= a;
        bus.dl           <= bot0;
        bus.dc           <= bot1;
        bus.dr           <= bus.pix_in;
        bus.coordinate_X <= pixRow - 1'b1;
        bus.coordinate_Y <= pixCol - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on an 8x6 image. A frame-level reference
// (image array indexed by raster position) predicts every output each cycle.
module tb_sobel_window_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CB = 11;

  logic CAMERA_CLK;
  logic rst;

  sobel_window_gen_if #(.COORD_BITS(CB)) busIf ();

  sobel_window_gen #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .COORD_BITS (CB)
  ) dut (
    .CAMERA_CLK (CAMERA_CLK),
    .rst        (rst),
    .bus        (busIf)
  );

  initial CAMERA_CLK = 1'b0;
  always #5 CAMERA_CLK = ~CAMERA_CLK;

  int testsRun    = 0;
  int testsFailed = 0;

  // reference model state
  bit          mStream;
  int          mRow, mCol;
  logic [7:0]  img [H][W];
  logic        eWin, eDone, eErr;
  logic [71:0] eTaps;
  logic [CB-1:0] eX, eY;

  // per-frame observations
  int          obsWins, doneCount;
  logic [71:0] firstTaps;
  logic [CB-1:0] firstX, firstY;

  task automatic checkVal(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [71:0] obsTaps();
    return {busIf.ul, busIf.uc, busIf.ur, busIf.ml, busIf.mc, busIf.mr,
            busIf.dl, busIf.dc, busIf.dr};
  endfunction

  task automatic checkOutputs();
    checkVal("win_valid", busIf.win_valid, eWin);
    checkVal("frame_done", busIf.frame_done, eDone);
    checkVal("sync_err", busIf.sync_err, eErr);
    checkVal("taps", obsTaps(), eTaps);
    checkVal("coordX", busIf.coordinate_X, eX);
    checkVal("coordY", busIf.coordinate_Y, eY);
    if (busIf.win_valid === 1'b1) begin
      if (obsWins == 0) begin
        firstTaps = obsTaps();
        firstX    = busIf.coordinate_X;
        firstY    = busIf.coordinate_Y;
      end
      obsWins++;
    end
    if (busIf.frame_done === 1'b1) doneCount++;
  endtask

  task automatic modelReset();
    mStream = 0;
    mRow    = 0;
    mCol    = 0;
    eWin    = 0;
    eDone   = 0;
    eErr    = 0;
    eTaps   = '0;
    eX      = '0;
    eY      = '0;
  endtask

  // One clock: check the outputs produced by the previous cycle's inputs,
  // then drive new inputs and predict what they will produce.
  task automatic tick(input bit v, input bit s, input logic [7:0] p);
    int r, c;
    @(negedge CAMERA_CLK);
    checkOutputs();
    busIf.pix_valid = v;
    busIf.sof       = s;
    busIf.pix_in    = p;
    eWin  = 0;
    eDone = 0;
    if (v && (mStream || s)) begin
      if (s) begin
        if (mStream) eErr = 1;
        r = 0;
        c = 0;
      end else begin
        r = mRow;
        c = mCol;
      end
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        eWin  = 1;
        eTaps = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                 img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                 img[r][c-2],   img[r][c-1],   img[r][c]};
        eX = CB'(r - 1);
        eY = CB'(c - 1);
      end
      if (!s && r == H - 1 && c == W - 1) begin
        eDone   = 1;
        mStream = 0;
        mRow    = 0;
        mCol    = 0;
      end else begin
        mStream = 1;
        if (c == W - 1) begin
          mCol = 0;
          mRow = r + 1;
        end else begin
          mCol = c + 1;
          mRow = r;
        end
      end
    end
  endtask

  task automatic doReset();
    @(negedge CAMERA_CLK);
    checkOutputs();
    rst             = 1;
    busIf.pix_valid = 0;
    busIf.sof       = 0;
    modelReset();
    @(negedge CAMERA_CLK);
    checkOutputs();
    rst = 0;
  endtask

  // Full frame with sof on the first pixel; stallPct chance of idle cycles
  // (with random sof/pixel noise) before each pixel.
  task automatic sendFrame(input bit randPix, input int stallPct);
    logic [7:0] p;
    int n;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        while (n < 6 && $urandom_range(99) < stallPct) begin
          tick(0, 1'($urandom_range(1)), 8'($urandom));
          n++;
        end
        p = randPix ? 8'($urandom) : 8'(r * 16 + c);
        tick(1, (r == 0 && c == 0), p);
        if (r == 0 && c == 0) begin
          obsWins   = 0;
          doneCount = 0;
        end
      end
    end
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
  endtask

  task automatic partialFrame(input int count);
    for (int i = 0; i < count; i++) begin
      tick(1, (i == 0), 8'((i / W) * 16 + (i % W)));
    end
  endtask

  task automatic checkPatternFrame(input string tag);
    checkVal({tag, "_winCount"}, obsWins, 24);
    checkVal({tag, "_doneCount"}, doneCount, 1);
    checkVal({tag, "_firstTaps"}, firstTaps, 72'h000102101112202122);
    checkVal({tag, "_firstX"}, firstX, 1);
    checkVal({tag, "_firstY"}, firstY, 1);
    checkVal({tag, "_lastTaps"}, obsTaps(), 72'h353637454647555657);
    checkVal({tag, "_lastX"}, busIf.coordinate_X, 4);
    checkVal({tag, "_lastY"}, busIf.coordinate_Y, 6);
  endtask

  initial begin
    rst             = 1;
    busIf.pix_valid = 0;
    busIf.sof       = 0;
    busIf.pix_in    = '0;
    obsWins         = 0;
    doneCount       = 0;
    modelReset();
    repeat (2) @(negedge CAMERA_CLK);
    checkOutputs();
    rst = 0;

    // continuous pattern frame
    sendFrame(0, 0);
    checkPatternFrame("plain");

    // same frame with random stalls
    sendFrame(0, 50);
    checkPatternFrame("stall");

    // pixels before sof are dropped
    for (int i = 0; i < 10; i++) tick(1, 0, 8'($urandom));
    sendFrame(1, 30);
    checkVal("presof_winCount", obsWins, 24);
    checkVal("presof_doneCount", doneCount, 1);

    // sof arriving at pixel (3,4) restarts the frame
    partialFrame(3 * W + 4);
    sendFrame(0, 0);
    checkVal("midsof_syncErr", busIf.sync_err, 1);
    checkPatternFrame("midsof");

    // reset at row 3, then ignored pixels, then two clean frames
    partialFrame(3 * W + 2);
    doReset();
    checkVal("rst_syncErr", busIf.sync_err, 0);
    checkVal("rst_taps", obsTaps(), 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 8'($urandom));
    sendFrame(1, 40);
    checkVal("after_rst1_winCount", obsWins, 24);
    sendFrame(1, 40);
    checkVal("after_rst2_winCount", obsWins, 24);
    checkVal("after_rst2_doneCount", doneCount, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator placed directly upstream of the Sobel frame buffer.
- Accepts one 8-bit grayscale camera pixel per cycle in raster order and buffers two previous image rows in line memories.
- Emits the nine window taps ul..dr plus the centre pixel's row/column coordinates, ready for the Sobel edge-detect/write-back path.
- Produces only interior windows, i.e. those with a full 3x3 neighbourhood.

Parameters:
- WIDTH, 768, image width in pixels (>=3).
- HEIGHT, 512, image height in pixels (>=3).
- COORD_BITS, 11, width of the coordinate outputs; must satisfy 2^COORD_BITS > max(WIDTH, HEIGHT).

Ports:
- CAMERA_CLK  input  1  pixel clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_valid  input  1  pix_in and sof are valid this cycle.
- pix_in  input  8  grayscale pixel.
- sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- win_valid  output  1  window taps and coordinates are valid this cycle.
- ul, uc, ur  output  8 each  top row of the window: row r-2, columns c-2, c-1, c.
- ml, mc, mr  output  8 each  middle row of the window: row r-1.
- dl, dc, dr  output  8 each  bottom row of the window: row r, the current row.
- coordinate_X  output  COORD_BITS  centre row (r-1).
- coordinate_Y  output  COORD_BITS  centre column (c-1).
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
- sync_err  output  1  sticky flag: sof arrived mid-frame.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; row and column counters are 0.
  - Line memory contents are not reset. Stale data is never emitted, because rows 0 and 1 of each frame refill the memories before any window is produced.
- FSM states: IDLE, STREAM.
  - IDLE: pixels are ignored until pix_valid && sof. That pixel is treated as (0,0) and the FSM moves to STREAM.
  - STREAM: each pix_valid cycle is one accepted pixel at (row, col).
  - When the pixel at (HEIGHT-1, WIDTH-1) is accepted: next cycle frame_done=1, counters return to 0, FSM returns to IDLE.
- Counters:
  - col increments per accepted pixel and wraps at WIDTH-1, at which point row increments.
  - Widths are sized to COORD_BITS.
- Line memories: two arrays, lineA (row r-1) and lineB (row r-2), each WIDTH x 8 bits. On an accepted pixel at column c:
  - Read a = lineA[c] and b = lineB[c].
  - Write lineB[c] <= a and lineA[c] <= pix_in.
  - Shift the three row registers left, inserting b (top), a (middle) and pix_in (bottom) as the right-column taps.
- Window emission:
  - Condition: the accepted pixel has row >= 2 and col >= 2.
  - Next cycle: win_valid=1, taps hold the registered window, coordinate_X=row-1, coordinate_Y=col-1.
  - Latency is one cycle from pixel acceptance.
- Output rules:
  - win_valid is 0 on every other cycle.
  - Taps and coordinates hold their last values when win_valid=0.
  - Each full frame yields exactly (WIDTH-2)*(HEIGHT-2) windows.
- Throughput:
  - Back-to-back pixels sustain one window per cycle.
  - Stalls: while pix_valid=0, counters, memories and shift registers hold.
- Row wrap: the shift registers are not cleared at a row start. Columns 0 and 1 of each row refill them before any window is emitted.
- sof in STREAM (mid-frame):
  - Set sync_err=1; it stays set until reset.
  - Restart: the pixel becomes (0,0) of a new frame.
  - No window is emitted for that pixel and no frame_done is produced.
- sof on the last pixel of a frame: this is treated as a mid-frame sof (restart plus sync_err); no frame_done.
- Reset mid-frame: all outputs return to 0 the next cycle and the FSM returns to IDLE. A new sof is required before processing resumes.

Test Plan:
- Bench setup: WIDTH=8, HEIGHT=6, pix_in=row*16+col, continuous pix_valid with sof on the first pixel.
- Window content: one cycle after (2,2) is accepted, win_valid=1, ul..dr=00,01,02,10,11,12,20,21,22, X=1, Y=1.
- Window count and frame end: the full frame yields exactly 24 win_valid pulses. The last has centre X=4, Y=6 and taps centred on 0x46. frame_done=1 for exactly one cycle after pixel (5,7).
- Stalls: pix_valid toggled randomly 50% -> identical window sequence and values; win_valid never asserted on a cycle following pix_valid=0.
- Pre-sof pixels: 10 pixels sent with sof=0 while IDLE -> no win_valid; the frame then starts correctly at the next sof.
- Mid-frame sof: sof at pixel (3,4) -> sync_err=1 (sticky). The following 48 pixels behave as a fresh frame with 24 windows and first centre (1,1); no frame_done for the aborted frame.
- Reset mid-frame: rst at row 3 -> next cycle all outputs are 0 and pixels are ignored until sof. The next frame's two back-to-back runs give matching outputs, proving the line memories refill without stale data.
